// File: rtl/regfile_pkg.sv
// Shared types and defaults for the R4 multi-port register file.
// Configuration macro used by regfile_mp: REGFILE_BYPASS_EN (same-cycle write forwarding).
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 6;

  typedef logic [DATA_W_DEF-1:0] reg_data_t;
  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  // $0 is hard-wired to zero: never written, never marked busy.
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for RAW hazard detection, plus a registered count of busy registers.
// Write-back clears a bit, issue (busySet) sets it; a set in the same cycle as a clear wins.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_WR = 2,
  localparam int DEPTH = 2 ** ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wrAddr,
  input  logic                     busySet,
  input  logic [ADDR_W-1:0]        busyAddr,
  output logic [DEPTH-1:0]         busy,
  output logic [ADDR_W:0]          busyCount
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

  logic [DEPTH-1:0]  set_vec;
  logic [DEPTH-1:0]  clr_vec;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W-1:0] wa;
  logic [ADDR_W:0]   inc;
  logic [ADDR_W:0]   dec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    wa      = '0;
    dec     = '0;
    if (busySet && (busyAddr != ZERO_ADDR)) set_vec[busyAddr] = 1'b1;
    // A decrement is counted once per distinct register that really drops 1->0,
    // so colliding write ports and set-overrides do not double count.
    for (int j = 0; j < NUM_WR; j++) begin
      wa = wrAddr[j*ADDR_W +: ADDR_W];
      if (we[j] && (wa != ZERO_ADDR)) begin
        if (busy[wa] && !set_vec[wa] && !clr_vec[wa]) dec = dec + CNT_ONE;
        clr_vec[wa] = 1'b1;
      end
    end
    inc      = ((set_vec & ~busy) != '0) ? CNT_ONE : '0;
    busy_nxt = (busy & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= '0;
      busyCount <= '0;
    end else begin
      busy      <= busy_nxt;
      busyCount <= busyCount + inc - dec;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, NUM_WR synchronous writes, zero register $0.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
  output logic [NUM_RD*DATA_W-1:0] rdData,
  output logic [NUM_RD-1:0]        rdBusy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wrAddr,
  input  logic [NUM_WR*DATA_W-1:0] wrData,
  input  logic                     busySet,
  input  logic [ADDR_W-1:0]        busyAddr,
  output logic [ADDR_W:0]          busyCount
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  // No handshakes: every enabled write, read and busySet is accepted in the cycle it is presented.

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .wrAddr    (wrAddr),
    .busySet   (busySet),
    .busyAddr  (busyAddr),
    .busy      (busy),
    .busyCount (busyCount)
  );

  // Entry 0 is only ever loaded by reset, so reading it always yields zero.
  // Ascending port order lets the highest-index port win a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && (wrAddr[j*ADDR_W +: ADDR_W] != ZERO_ADDR))
          mem[wrAddr[j*ADDR_W +: ADDR_W]] <= wrData[j*DATA_W +: DATA_W];
      end
    end
  end

  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rd_val;
  logic              rd_bsy;

  always_comb begin
    rdData = '0;
    rdBusy = '0;
    ra     = '0;
    rd_val = '0;
    rd_bsy = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra     = rdAddr[i*ADDR_W +: ADDR_W];
      rd_val = mem[ra];
      rd_bsy = busy[ra];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && (wrAddr[j*ADDR_W +: ADDR_W] != ZERO_ADDR) &&
            (wrAddr[j*ADDR_W +: ADDR_W] == ra)) begin
          rd_val = wrData[j*DATA_W +: DATA_W];
          rd_bsy = busySet && (busyAddr == ra);
        end
      end
`endif
      rdData[i*DATA_W +: DATA_W] = rd_val;
      rdBusy[i]                  = rd_bsy;
    end
  end

endmodule
